// File: rtl/quad_dec_pkg.sv
// quad_dec_pkg: shared types and Gray-code helpers for quad_decoder.
// Holds FSM states, step directions and the dir() classifier.
package quad_dec_pkg;

  typedef enum logic {
    SETTLE,
    TRACK
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_ERR
  } dir_t;

  // Forward rotation order of {A,B}
  localparam logic [1:0] G0 = 2'b00;
  localparam logic [1:0] G1 = 2'b01;
  localparam logic [1:0] G2 = 2'b11;
  localparam logic [1:0] G3 = 2'b10;

  function automatic logic [1:0] fwd(input logic [1:0] g);
    logic [1:0] n;
    n = G0;
    case (g)
      G0:      n = G1;
      G1:      n = G2;
      G2:      n = G3;
      default: n = G0;
    endcase
    return n;
  endfunction

  function automatic dir_t dir(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    dir_t d;
    d = DIR_NONE;
    unique case (1'b1)
      (prev == cur):      d = DIR_NONE;
      (&(prev ^ cur)):    d = DIR_ERR;
      (fwd(prev) == cur): d = DIR_UP;
      default:            d = DIR_DOWN;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/quad_decoder_glitch_filter.sv
// glitch_filter: accepts a new level only after FILTER_LEN consecutive
// differing samples. Ports: clk, reset (async low), din, dout.
module glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= 1'b0;
      cnt  <= '0;
    end else if (din == dout) begin
      cnt  <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: sync, deglitch and Gray-decode a quadrature encoder.
// Ports: clk, reset (async low), enc_a, enc_b, clr -> up, down, err, pos.
module quad_decoder
  import quad_dec_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               clr,
  output logic               up,
  output logic               down,
  output logic               err,
  output logic [COUNT_W-1:0] pos
);

  localparam int SW = $clog2(FILTER_LEN + 3);

  // bit 1 = channel A, bit 0 = channel B
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    filt;
  logic [1:0]    prev;
  logic [1:0]    prev_n;
  logic [SW-1:0] settle_cnt;
  logic          settle_done;
  state_t        state;
  state_t        state_n;
  dir_t          d;
  logic          up_n;
  logic          down_n;
  logic          err_n;

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk  (clk),
    .reset(reset),
    .din  (s2[1]),
    .dout (filt[1])
  );

  glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk  (clk),
    .reset(reset),
    .din  (s2[0]),
    .dout (filt[0])
  );

  assign settle_done = (settle_cnt == SW'(FILTER_LEN + 2));
  assign d = dir(prev, filt);

  always_comb begin
    state_n = state;
    prev_n  = prev;
    up_n    = 1'b0;
    down_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      SETTLE: begin
        if (settle_done) begin
          state_n = TRACK;
          prev_n  = filt;
        end
      end
      TRACK: begin
        prev_n = filt;
        up_n   = (d == DIR_UP);
        down_n = (d == DIR_DOWN);
        err_n  = (d == DIR_ERR);
      end
      default: state_n = SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1         <= '0;
      s2         <= '0;
      prev       <= '0;
      settle_cnt <= '0;
      state      <= SETTLE;
      up         <= 1'b0;
      down       <= 1'b0;
      err        <= 1'b0;
      pos        <= '0;
    end else begin
      s1    <= {enc_a, enc_b};
      s2    <= s1;
      prev  <= prev_n;
      state <= state_n;
      up    <= up_n;
      down  <= down_n;
      err   <= err_n;
      if (state == SETTLE && !settle_done)
        settle_cnt <= settle_cnt + SW'(1);
      // clear beats a coincident step
      if (clr)
        pos <= '0;
      else if (up_n)
        pos <= pos + COUNT_W'(1);
      else if (down_n)
        pos <= pos - COUNT_W'(1);
    end
  end

endmodule
